// File: rtl/fp_pkg.sv
// Shared constants and types for the FP write-back path.
// The queue's occupancy state (EMPTY/PARTIAL/FULL) is decoded from its entry count.
package fp_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  typedef enum logic [1:0] {
    Q_EMPTY   = 2'd0,
    Q_PARTIAL = 2'd1,
    Q_FULL    = 2'd2
  } q_state_t;

  function automatic q_state_t occ_state(input int unsigned count, input int unsigned depth);
    q_state_t s;
    if (count == 0)           s = Q_EMPTY;
    else if (count >= depth)  s = Q_FULL;
    else                      s = Q_PARTIAL;
    return s;
  endfunction

endpackage

// File: rtl/fp_wb_fifo.sv
// Photon write queue: circular entry storage with per-entry valid bits,
// address-based squash and a combinational pending-write match for decode.
module fp_wb_fifo
  import fp_pkg::*;
#(
  parameter int DATA_W     = XLEN,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enq_i,
  input  logic                        enq_valid_i,
  input  logic [ADDR_W-1:0]           enq_rd_i,
  input  logic [DATA_W-1:0]           enq_data_i,
  input  logic                        deq_i,
  input  logic                        squash_i,
  input  logic [ADDR_W-1:0]           squash_rd_i,
  input  logic [ADDR_W-1:0]           chk_addr_i,
  output logic                        chk_hit_o,
  output logic                        head_valid_o,
  output logic [ADDR_W-1:0]           head_rd_o,
  output logic [DATA_W-1:0]           head_data_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output q_state_t                    state_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0]     rd_q   [FIFO_DEPTH];
  logic [DATA_W-1:0]     data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic [FIFO_DEPTH-1:0] squash_vec;
  logic [FIFO_DEPTH-1:0] chk_vec;

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_match
      assign squash_vec[gi] = squash_i && (rd_q[gi] == squash_rd_i);
      assign chk_vec[gi]    = valid_q[gi] && (rd_q[gi] == chk_addr_i);
    end
  endgenerate

  // Vacated slots must drop their valid bit so chk_hit only sees live entries.
  always_comb begin
    valid_d = valid_q & ~squash_vec;
    if (deq_i) valid_d[rd_ptr_q] = 1'b0;
    if (enq_i) valid_d[wr_ptr_q] = enq_valid_i;
  end

  always_comb begin
    wr_ptr_d = enq_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq_i ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({enq_i, deq_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_i) begin
      rd_q[wr_ptr_q]   <= enq_rd_i;
      data_q[wr_ptr_q] <= enq_data_i;
    end
  end

  assign chk_hit_o    = (|chk_vec) && (chk_addr_i != '0);
  assign head_valid_o = valid_q[rd_ptr_q];
  assign head_rd_o    = rd_q[rd_ptr_q];
  assign head_data_o  = data_q[rd_ptr_q];
  assign count_o      = count_q;
  assign state_o      = occ_state(32'(count_q), 32'(FIFO_DEPTH));

endmodule

// File: rtl/fp_wb_arbiter.sv
// FP register-file write-back arbiter: pipeline writes win, photon writes
// are queued and drained into idle cycles through one registered write port.
module fp_wb_arbiter
  import fp_pkg::*;
#(
  parameter int DATA_W     = XLEN,
  parameter int ADDR_W     = REG_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        Rst_n,
  input  logic                        wb_regwrite,
  input  logic [ADDR_W-1:0]           wb_rd,
  input  logic [DATA_W-1:0]           wb_data,
  input  logic                        mem_hold,
  input  logic                        cp_valid,
  output logic                        cp_ready,
  input  logic [ADDR_W-1:0]           cp_rd,
  input  logic [DATA_W-1:0]           cp_data,
  output logic                        rf_wen,
  output logic [ADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]           rf_wdata,
  input  logic [ADDR_W-1:0]           chk_addr,
  output logic                        chk_hit,
  output logic [$clog2(FIFO_DEPTH):0] q_count
);

  logic              pw;
  logic              cp_accept;
  logic              enq;
  logic              enq_valid;
  logic              deq;
  logic              head_valid;
  logic [ADDR_W-1:0] head_rd;
  logic [DATA_W-1:0] head_data;
  q_state_t          q_state;

  logic              ready_en_q;
  logic              rf_wen_q, rf_wen_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  assign pw = wb_regwrite && (wb_rd != '0) && !mem_hold;

  // ready_en_q keeps cp_ready low until the first edge after reset release.
  assign cp_ready  = ready_en_q && (q_state != Q_FULL);
  assign cp_accept = cp_valid && cp_ready;
  assign enq       = cp_accept && (cp_rd != '0);
  assign enq_valid = !(pw && (cp_rd == wb_rd));
  assign deq       = !pw && (q_state != Q_EMPTY);

  fp_wb_fifo #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (Rst_n),
    .enq_i        (enq),
    .enq_valid_i  (enq_valid),
    .enq_rd_i     (cp_rd),
    .enq_data_i   (cp_data),
    .deq_i        (deq),
    .squash_i     (pw),
    .squash_rd_i  (wb_rd),
    .chk_addr_i   (chk_addr),
    .chk_hit_o    (chk_hit),
    .head_valid_o (head_valid),
    .head_rd_o    (head_rd),
    .head_data_o  (head_data),
    .count_o      (q_count),
    .state_o      (q_state)
  );

  always_comb begin
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (pw) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = wb_rd;
      rf_wdata_d = wb_data;
    end else if (deq && head_valid) begin
      rf_wen_d   = 1'b1;
      rf_waddr_d = head_rd;
      rf_wdata_d = head_data;
    end
  end

  always_ff @(posedge clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ready_en_q <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ready_en_q <= 1'b1;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_fp_wb_arbiter.sv
// Directed + randomized bench for fp_wb_arbiter against a queue-based reference model.
module tb_fp_wb_arbiter;
  import fp_pkg::*;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int FIFO_DEPTH = 4;

  logic              clk = 1'b0;
  logic              Rst_n = 1'b1;
  logic              wb_regwrite, mem_hold, cp_valid;
  logic [ADDR_W-1:0] wb_rd, cp_rd, chk_addr;
  logic [DATA_W-1:0] wb_data, cp_data;
  logic              cp_ready, rf_wen, chk_hit;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [2:0]        q_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  wb_req_t           mq[$];
  bit                started;
  logic              exp_wen;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  int                n_accepted = 0;

  fp_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .Rst_n(Rst_n),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data), .mem_hold(mem_hold),
    .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_rd(cp_rd), .cp_data(cp_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .chk_addr(chk_addr), .chk_hit(chk_hit), .q_count(q_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    wb_regwrite = 1'b0; wb_rd = '0; wb_data = '0; mem_hold = 1'b0;
    cp_valid = 1'b0; cp_rd = '0; cp_data = '0;
  endtask

  // Called just after a rising edge; leaves Rst_n released just after a rising edge.
  task automatic apply_reset(input int edges);
    Rst_n = 1'b0;
    #1;
    check("rst_wen", rf_wen, 1'b0);
    check("rst_waddr", rf_waddr, '0);
    check("rst_wdata", rf_wdata, '0);
    check("rst_qcount", q_count, '0);
    check("rst_ready", cp_ready, 1'b0);
    repeat (edges) begin
      @(posedge clk); #1;
      check("rst_hold_wen", rf_wen, 1'b0);
      check("rst_hold_qcount", q_count, '0);
      check("rst_hold_ready", cp_ready, 1'b0);
    end
    Rst_n = 1'b1;
    mq.delete();
    started  = 1'b0;
    exp_wen  = 1'b0;
    exp_addr = '0;
    exp_data = '0;
  endtask

  // One clock: check combinational outputs, advance the model, check registered outputs.
  task automatic cycle();
    bit      pw, rdy, hit, acc;
    wb_req_t h;
    @(negedge clk);
    pw  = wb_regwrite && (wb_rd != 0) && !mem_hold;
    rdy = started && (mq.size() != FIFO_DEPTH);
    hit = 1'b0;
    foreach (mq[i]) if (mq[i].valid && mq[i].rd == chk_addr && chk_addr != 0) hit = 1'b1;
    check("cp_ready", cp_ready, rdy);
    check("chk_hit", chk_hit, hit);
    check("q_count", q_count, 64'(mq.size()));
    acc = cp_valid && rdy;
    if (acc) n_accepted++;
    exp_wen = 1'b0;
    if (pw) begin
      exp_wen = 1'b1; exp_addr = wb_rd; exp_data = wb_data;
      foreach (mq[i]) if (mq[i].rd == wb_rd) mq[i].valid = 1'b0;
    end else if (mq.size() > 0) begin
      h = mq.pop_front();
      if (h.valid) begin
        exp_wen = 1'b1; exp_addr = h.rd; exp_data = h.data;
      end
    end
    if (acc && cp_rd != 0)
      mq.push_back('{valid: !(pw && cp_rd == wb_rd), rd: cp_rd, data: cp_data});
    started = 1'b1;
    @(posedge clk); #1;
    check("rf_wen", rf_wen, exp_wen);
    check("rf_waddr", rf_waddr, exp_addr);
    check("rf_wdata", rf_wdata, exp_data);
  endtask

  initial begin
    int acc0;
    idle();
    chk_addr = '0;
    Rst_n = 1'b0;
    @(posedge clk); #1;
    apply_reset(2);

    // Reset while a photon write is queued
    cycle();
    cp_valid = 1'b1; cp_rd = 5'd3; cp_data = 32'hAAAA;
    cycle();
    idle();
    check("queued_before_reset", q_count, 3'd1);
    apply_reset(3);
    cycle();

    // Pipeline only, then suppressed by mem_hold and by rd=0
    wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h12345678;
    cycle();
    check("pipe_wen", rf_wen, 1'b1);
    check("pipe_waddr", rf_waddr, 5'd5);
    check("pipe_wdata", rf_wdata, 32'h12345678);
    mem_hold = 1'b1; wb_data = 32'h0BAD0001;
    cycle();
    check("hold_wen", rf_wen, 1'b0);
    mem_hold = 1'b0; wb_rd = 5'd0;
    cycle();
    check("rd0_wen", rf_wen, 1'b0);

    // Photon priority and ordering
    wb_regwrite = 1'b1; wb_rd = 5'd20; wb_data = 32'h100;
    cp_valid = 1'b1; cp_rd = 5'd7; cp_data = 32'h11;
    cycle();
    cp_rd = 5'd8; cp_data = 32'h22; wb_data = 32'h101;
    cycle();
    cp_valid = 1'b0; wb_data = 32'h102;
    cycle();
    check("prio_queued", q_count, 3'd2);
    idle();
    cycle();
    check("drain_first_addr", rf_waddr, 5'd7);
    cycle();
    check("drain_second_addr", rf_waddr, 5'd8);
    cycle();
    check("drain_empty", q_count, 3'd0);

    // Full queue, twice so the pointers wrap
    for (int pass = 0; pass < 2; pass++) begin
      acc0 = n_accepted;
      wb_regwrite = 1'b1; wb_rd = 5'd30; cp_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
        wb_data = 32'h200 + 32'(k);
        cp_rd   = 5'(10 + k);
        cp_data = 32'h300 + 32'(k);
        cycle();
      end
      check("full_accepted", 64'(n_accepted - acc0), 64'd4);
      check("full_count", q_count, 3'd4);
      check("full_ready", cp_ready, 1'b0);
      idle();
      repeat (5) cycle();
    end

    // Squash by a newer pipeline write to the same register
    chk_addr = 5'd9;
    cp_valid = 1'b1; cp_rd = 5'd9; cp_data = 32'hDEAD;
    cycle();
    check("squash_hit_before", chk_hit, 1'b1);
    cp_valid = 1'b0;
    wb_regwrite = 1'b1; wb_rd = 5'd9; wb_data = 32'hBEEF;
    cycle();
    check("squash_hit_after", chk_hit, 1'b0);
    check("squash_wdata", rf_wdata, 32'hBEEF);
    idle();
    cycle();
    check("squash_drain_wen", rf_wen, 1'b0);

    // rd=0 photon write is accepted but dropped
    chk_addr = 5'd0;
    cp_valid = 1'b1; cp_rd = 5'd0; cp_data = 32'h5555;
    cycle();
    check("cp_rd0_count", q_count, 3'd0);
    check("cp_rd0_wen", rf_wen, 1'b0);
    idle();
    cycle();

    // Randomized traffic with a small register range to force conflicts
    for (int n = 0; n < 400; n++) begin
      wb_regwrite = 1'($urandom_range(0, 1));
      wb_rd       = 5'($urandom_range(0, 7));
      wb_data     = $urandom;
      mem_hold    = ($urandom_range(0, 3) == 0);
      cp_valid    = 1'($urandom_range(0, 1));
      cp_rd       = 5'($urandom_range(0, 7));
      cp_data     = $urandom;
      chk_addr    = 5'($urandom_range(0, 7));
      cycle();
      if (n == 200) apply_reset(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
